// File: rtl/z80_jr_cond_exec.sv
// Executes the Z80 conditional relative jump (JR NZ/Z/NC/C, e) as a multi-cycle
// sequence (M1, displacement read, optional internal cycle) and emits a retirement trace.
module z80_jr_cond_exec (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  opcode,
    input  logic [15:0] pc_in,
    input  logic [7:0]  f_in,
    input  logic        mem_wait,
    input  logic [7:0]  mem_rdata,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] pc_out,
    output logic        z80fi_valid,
    output logic [31:0] z80fi_insn,
    output logic [3:0]  z80fi_insn_len,
    output logic [15:0] z80fi_reg_ip_in,
    output logic [15:0] z80fi_reg_ip_out,
    output logic [7:0]  z80fi_reg_f_in,
    output logic [2:0]  z80fi_mcycle_type1,
    output logic [2:0]  z80fi_mcycle_type2,
    output logic [2:0]  z80fi_mcycle_type3,
    output logic [2:0]  z80fi_mcycle_type4,
    output logic [3:0]  z80fi_tcycles1,
    output logic [3:0]  z80fi_tcycles2,
    output logic [3:0]  z80fi_tcycles3
);

    localparam logic [2:0] CYCLE_NONE     = 3'd0;
    localparam logic [2:0] CYCLE_M1       = 3'd1;
    localparam logic [2:0] CYCLE_RDWR_MEM = 3'd2;
    localparam logic [2:0] CYCLE_INTERNAL = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_M1,
        S_RD,
        S_INT,
        S_RETIRE
    } state_t;

    state_t      state, state_next;
    logic [2:0]  tcnt, tcnt_next;

    logic [7:0]  op_q;
    logic [7:0]  f_q;
    logic [15:0] pc_q;
    logic [7:0]  e_q;
    logic [3:0]  tcyc2_q;
    logic        err_q;

    logic [15:0] pc_out_q;
    logic [31:0] tr_insn;
    logic [3:0]  tr_len;
    logic [15:0] tr_ip_in;
    logic [15:0] tr_ip_out;
    logic [7:0]  tr_f;
    logic [2:0]  tr_type1, tr_type2, tr_type3, tr_type4;
    logic [3:0]  tr_tc1, tr_tc2, tr_tc3;

    logic        bad_op;
    logic        accept;
    logic [1:0]  cc;
    logic        flag;
    logic        taken;
    logic [7:0]  e_eff;
    logic [15:0] pc_next;
    logic        retire_load;

    assign bad_op = !((opcode[7:5] == 3'b001) && (opcode[2:0] == 3'b000));
    assign accept = (state == S_IDLE) && start && !bad_op;

    assign cc    = op_q[4:3];
    assign flag  = cc[1] ? f_q[0] : f_q[6];
    assign taken = (flag == cc[0]);

    // Not-taken jumps retire on the same edge that samples e, so use the live bus byte then.
    assign e_eff   = (state == S_RD) ? mem_rdata : e_q;
    assign pc_next = pc_q + 16'd2 + (taken ? {{8{e_eff[7]}}, e_eff} : 16'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            tcnt  <= '0;
        end else begin
            state <= state_next;
            tcnt  <= tcnt_next;
        end
    end

    always_comb begin
        state_next = state;
        tcnt_next  = tcnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_M1;
                    tcnt_next  = '0;
                end
            end
            S_M1: begin
                if (tcnt == 3'd2) begin
                    state_next = S_RD;
                    tcnt_next  = '0;
                end else begin
                    tcnt_next = tcnt + 3'd1;
                end
            end
            S_RD: begin
                case (tcnt)
                    3'd0: tcnt_next = 3'd1;
                    3'd1: if (!mem_wait) tcnt_next = 3'd2;
                    default: begin
                        state_next = taken ? S_INT : S_RETIRE;
                        tcnt_next  = '0;
                    end
                endcase
            end
            S_INT: begin
                if (tcnt == 3'd4) begin
                    state_next = S_RETIRE;
                    tcnt_next  = '0;
                end else begin
                    tcnt_next = tcnt + 3'd1;
                end
            end
            S_RETIRE: begin
                state_next = S_IDLE;
                tcnt_next  = '0;
            end
            default: begin
                state_next = S_IDLE;
                tcnt_next  = '0;
            end
        endcase
    end

    assign retire_load = (state_next == S_RETIRE) && (state != S_RETIRE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q      <= '0;
            f_q       <= '0;
            pc_q      <= '0;
            e_q       <= '0;
            tcyc2_q   <= '0;
            err_q     <= 1'b0;
            pc_out_q  <= '0;
            tr_insn   <= '0;
            tr_len    <= '0;
            tr_ip_in  <= '0;
            tr_ip_out <= '0;
            tr_f      <= '0;
            tr_type1  <= CYCLE_NONE;
            tr_type2  <= CYCLE_NONE;
            tr_type3  <= CYCLE_NONE;
            tr_type4  <= CYCLE_NONE;
            tr_tc1    <= '0;
            tr_tc2    <= '0;
            tr_tc3    <= '0;
        end else begin
            err_q <= (state == S_IDLE) && start && bad_op;
            if (accept) begin
                op_q    <= opcode;
                f_q     <= f_in;
                pc_q    <= pc_in;
                tcyc2_q <= 4'd3;
            end
            if ((state == S_RD) && (tcnt == 3'd1) && mem_wait && (tcyc2_q != 4'd15)) begin
                tcyc2_q <= tcyc2_q + 4'd1;
            end
            if ((state == S_RD) && (tcnt == 3'd2)) begin
                e_q <= mem_rdata;
            end
            if (retire_load) begin
                pc_out_q  <= pc_next;
                tr_insn   <= {16'h0000, e_eff, op_q};
                tr_len    <= 4'd2;
                tr_ip_in  <= pc_q;
                tr_ip_out <= pc_next;
                tr_f      <= f_q;
                tr_type1  <= CYCLE_M1;
                tr_type2  <= CYCLE_RDWR_MEM;
                tr_type3  <= taken ? CYCLE_INTERNAL : CYCLE_NONE;
                tr_type4  <= CYCLE_NONE;
                tr_tc1    <= 4'd4;
                tr_tc2    <= tcyc2_q;
                tr_tc3    <= taken ? 4'd5 : 4'd0;
            end
        end
    end

    assign mem_rd   = (state == S_RD);
    assign mem_addr = mem_rd ? (pc_q + 16'd1) : 16'd0;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_RETIRE);
    assign err      = err_q;
    assign pc_out   = pc_out_q;

    assign z80fi_valid        = done;
    assign z80fi_insn         = tr_insn;
    assign z80fi_insn_len     = tr_len;
    assign z80fi_reg_ip_in    = tr_ip_in;
    assign z80fi_reg_ip_out   = tr_ip_out;
    assign z80fi_reg_f_in     = tr_f;
    assign z80fi_mcycle_type1 = tr_type1;
    assign z80fi_mcycle_type2 = tr_type2;
    assign z80fi_mcycle_type3 = tr_type3;
    assign z80fi_mcycle_type4 = tr_type4;
    assign z80fi_tcycles1     = tr_tc1;
    assign z80fi_tcycles2     = tr_tc2;
    assign z80fi_tcycles3     = tr_tc3;

endmodule
